// File: rtl/count_wrap_monitor_pkg.sv
// Shared FSM state encoding and transition classes for the count wrap monitor.
`timescale 1ns/1ps
package count_wrap_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LEGAL_INC = 2'd0,
        WRAP      = 2'd1,
        CLEAR     = 2'd2,
        ILLEGAL   = 2'd3
    } step_cls_t;

endpackage

// File: rtl/count_step_classifier.sv
// Combinational classifier of one counter step (prev -> count_in).
`timescale 1ns/1ps
module count_step_classifier
    import count_wrap_monitor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] count_in,
    output step_cls_t        step_cls
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] expected;
    assign expected = prev + WIDTH'(1);

    // Wrap must be tested before clear: both see count_in == 0.
    always_comb begin
        step_cls = ILLEGAL;
        if (prev == MAX && count_in == '0) begin
            step_cls = WRAP;
        end else if (count_in == '0) begin
            step_cls = CLEAR;
        end else if (prev != MAX && count_in == expected) begin
            step_cls = LEGAL_INC;
        end
    end

endmodule

// File: rtl/count_wrap_monitor.sv
// Checks an upstream up-counter for +1/clear steps; reports wraps, matches and sticky errors.
`timescale 1ns/1ps
module count_wrap_monitor
    import count_wrap_monitor_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int WRAP_W    = 8,
    parameter int ERR_LIMIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_in,
    input  logic [WIDTH-1:0]  cmp_val,
    input  logic              clr_err,
    output logic              match_pulse,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              seq_err,
    output logic [1:0]        state
);

    localparam int MIS_W = $clog2(ERR_LIMIT + 1);

    state_t            cur_state, nxt_state;
    step_cls_t         step_cls;
    logic [WIDTH-1:0]  prev;
    logic [MIS_W-1:0]  mis_cnt, nxt_mis, mis_inc;
    logic              nxt_wrap_pulse, nxt_seq_err;
    logic [WRAP_W-1:0] nxt_wrap_count;

    count_step_classifier #(.WIDTH(WIDTH)) u_classifier (
        .prev     (prev),
        .count_in (count_in),
        .step_cls (step_cls)
    );

    assign mis_inc = mis_cnt + MIS_W'(1);
    assign state   = cur_state;

    always_comb begin
        nxt_state      = cur_state;
        nxt_mis        = mis_cnt;
        nxt_wrap_pulse = 1'b0;
        nxt_wrap_count = wrap_count;
        nxt_seq_err    = seq_err;
        case (cur_state)
            ST_IDLE: begin
                nxt_state = ST_TRACK;
            end
            ST_TRACK: begin
                case (step_cls)
                    WRAP: begin
                        nxt_wrap_pulse = 1'b1;
                        nxt_wrap_count = wrap_count + WRAP_W'(1);
                        nxt_mis        = '0;
                    end
                    LEGAL_INC, CLEAR: nxt_mis = '0;
                    default: begin
                        // clr_err on the same edge cancels the illegal sample
                        if (!clr_err) begin
                            nxt_mis = mis_inc;
                            if (mis_inc >= MIS_W'(ERR_LIMIT)) begin
                                nxt_state   = ST_ERROR;
                                nxt_seq_err = 1'b1;
                            end
                        end
                    end
                endcase
                if (clr_err) nxt_mis = '0;
            end
            ST_ERROR: begin
                if (clr_err) begin
                    nxt_state   = ST_IDLE;
                    nxt_seq_err = 1'b0;
                    nxt_mis     = '0;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state   <= ST_IDLE;
            prev        <= '0;
            mis_cnt     <= '0;
            match_pulse <= 1'b0;
            wrap_pulse  <= 1'b0;
            wrap_count  <= '0;
            seq_err     <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            prev        <= count_in;
            mis_cnt     <= nxt_mis;
            match_pulse <= (count_in == cmp_val);
            wrap_pulse  <= nxt_wrap_pulse;
            wrap_count  <= nxt_wrap_count;
            seq_err     <= nxt_seq_err;
        end
    end

endmodule
